// File: rtl/vault_sequencer.sv
// Master sequencer for the five vault puzzle phases: starts each phase in turn,
// rolls play back on failures, and ends in either a full escape or a lockout.
module vault_sequencer #(
  parameter int MAX_FAILS     = 3,
  parameter int PHASE_TIMEOUT = 1000,
  parameter int ALARM_HOLD    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic [4:0] phase_done,
  input  logic [4:0] phase_fail,
  output logic [4:0] phase_start,
  output logic       phase_clear,
  output logic [2:0] cur_phase,
  output logic [3:0] fail_count,
  output logic       alarm,
  output logic       lockout,
  output logic       all_done,
  output logic       vault_escape
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CLEAR   = 3'd1;
  localparam logic [2:0] ST_RUN     = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_LOCKOUT = 3'd4;

  localparam int TW = $clog2(PHASE_TIMEOUT + 2);
  localparam int AW = $clog2(ALARM_HOLD + 1);
  localparam bit TIMEOUT_EN = (PHASE_TIMEOUT != 0);
  localparam logic [TW-1:0] TIMER_LAST = TW'((PHASE_TIMEOUT > 0) ? PHASE_TIMEOUT - 1 : 0);
  localparam logic [AW-1:0] ALARM_LOAD = AW'(ALARM_HOLD);
  localparam logic [3:0]    FAIL_LIMIT = 4'(MAX_FAILS);

  logic [2:0]    state, state_nx;
  logic [2:0]    target, target_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [AW-1:0] alarm_cnt, alarm_cnt_nx;
  logic [3:0]    fail_count_nx;
  logic [4:0]    active_mask;
  logic          hit_done, hit_fail, timed_out, fail_event;

  logic [4:0]    phase_start_nx;
  logic [2:0]    cur_phase_nx;
  logic          phase_clear_nx, alarm_nx, lockout_nx, all_done_nx, vault_escape_nx;

  // Only the active phase's done/fail bits matter; target is 0 in IDLE so the mask is empty.
  assign active_mask = 5'b00001 << (target - 3'd1);
  assign hit_done    = |(phase_done & active_mask);
  assign hit_fail    = |(phase_fail & active_mask);
  assign timed_out   = TIMEOUT_EN && (timer == TIMER_LAST) && !hit_done;
  assign fail_event  = hit_fail || timed_out;

  always_comb begin
    state_nx      = state;
    target_nx     = target;
    timer_nx      = timer;
    fail_count_nx = fail_count;
    alarm_cnt_nx  = (alarm_cnt != '0) ? alarm_cnt - 1'b1 : alarm_cnt;

    case (state)
      ST_IDLE: begin
        if (go) begin
          state_nx  = ST_CLEAR;
          target_nx = 3'd1;
        end
      end
      ST_CLEAR: begin
        state_nx = ST_RUN;
        timer_nx = '0;
      end
      ST_RUN: begin
        timer_nx = timer + 1'b1;
        if (fail_event) begin
          if (fail_count != FAIL_LIMIT) fail_count_nx = fail_count + 4'd1;
          if (fail_count_nx == FAIL_LIMIT) begin
            state_nx = ST_LOCKOUT;
          end else begin
            // Phase 1 retries itself; every later phase falls back to phase 2.
            alarm_cnt_nx = ALARM_LOAD;
            state_nx     = ST_CLEAR;
            target_nx    = (target == 3'd1) ? 3'd1 : 3'd2;
          end
        end else if (hit_done) begin
          if (target == 3'd5) begin
            state_nx = ST_DONE;
          end else begin
            state_nx  = ST_CLEAR;
            target_nx = target + 3'd1;
          end
        end
      end
      ST_DONE, ST_LOCKOUT: state_nx = state;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they can be registered without lag.
  always_comb begin
    phase_start_nx  = (state_nx == ST_RUN) ? (5'b00001 << (target_nx - 3'd1)) : 5'b00000;
    phase_clear_nx  = (state_nx == ST_CLEAR);
    lockout_nx      = (state_nx == ST_LOCKOUT);
    all_done_nx     = (state_nx == ST_DONE);
    vault_escape_nx = (state_nx == ST_DONE) && (state != ST_DONE);
    alarm_nx        = (alarm_cnt_nx != '0) || lockout_nx;
    case (state_nx)
      ST_CLEAR, ST_RUN: cur_phase_nx = target_nx;
      ST_DONE:          cur_phase_nx = 3'd6;
      ST_LOCKOUT:       cur_phase_nx = 3'd7;
      default:          cur_phase_nx = 3'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      target       <= 3'd0;
      timer        <= '0;
      alarm_cnt    <= '0;
      fail_count   <= 4'd0;
      phase_start  <= 5'b00000;
      phase_clear  <= 1'b0;
      cur_phase    <= 3'd0;
      alarm        <= 1'b0;
      lockout      <= 1'b0;
      all_done     <= 1'b0;
      vault_escape <= 1'b0;
    end else begin
      state        <= state_nx;
      target       <= target_nx;
      timer        <= timer_nx;
      alarm_cnt    <= alarm_cnt_nx;
      fail_count   <= fail_count_nx;
      phase_start  <= phase_start_nx;
      phase_clear  <= phase_clear_nx;
      cur_phase    <= cur_phase_nx;
      alarm        <= alarm_nx;
      lockout      <= lockout_nx;
      all_done     <= all_done_nx;
      vault_escape <= vault_escape_nx;
    end
  end

endmodule

// File: tb/tb_vault_sequencer.sv
// Self-checking bench for vault_sequencer: a constant vector table, hand-written
// corner sequences and randomized play compared against a behavioural model.
module tb_vault_sequencer;

  localparam int MAX_FAILS     = 3;
  localparam int PHASE_TIMEOUT = 10;
  localparam int ALARM_HOLD    = 8;

  localparam int M_IDLE = 0, M_CLEAR = 1, M_RUN = 2, M_DONE = 3, M_LOCK = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       go = 1'b0;
  logic [4:0] phase_done = '0;
  logic [4:0] phase_fail = '0;
  logic [4:0] phase_start;
  logic       phase_clear;
  logic [2:0] cur_phase;
  logic [3:0] fail_count;
  logic       alarm, lockout, all_done, vault_escape;
  logic [16:0] dut_vec;

  int n_checks = 0;
  int n_fail   = 0;

  int m_mode, m_phase, m_fails, m_run_cycles, m_alarm_left;
  bit m_escape;

  typedef struct {
    logic        go;
    logic [4:0]  done;
    logic [4:0]  fail;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl[18];

  vault_sequencer #(
    .MAX_FAILS(MAX_FAILS),
    .PHASE_TIMEOUT(PHASE_TIMEOUT),
    .ALARM_HOLD(ALARM_HOLD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .go(go),
    .phase_done(phase_done),
    .phase_fail(phase_fail),
    .phase_start(phase_start),
    .phase_clear(phase_clear),
    .cur_phase(cur_phase),
    .fail_count(fail_count),
    .alarm(alarm),
    .lockout(lockout),
    .all_done(all_done),
    .vault_escape(vault_escape)
  );

  always #5 clk = ~clk;

  assign dut_vec = {cur_phase, phase_start, phase_clear, fail_count, alarm, lockout, all_done, vault_escape};

  function automatic logic [16:0] outs(int cur, logic [4:0] st, bit clr, int fc, bit al, bit lk, bit ad, bit ve);
    return {3'(cur), st, clr, 4'(fc), al, lk, ad, ve};
  endfunction

  function automatic vec_t mk(logic g, logic [4:0] d, logic [4:0] f, logic [16:0] e);
    vec_t v;
    v.go = g; v.done = d; v.fail = f; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got cur=%0d start=%b clr=%b fc=%0d al=%b lk=%b ad=%b ve=%b, expected cur=%0d start=%b clr=%b fc=%0d al=%b lk=%b ad=%b ve=%b",
               name, $time, act[16:14], act[13:9], act[8], act[7:4], act[3], act[2], act[1], act[0],
               exp[16:14], exp[13:9], exp[8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [16:0] model_exp();
    int cur;
    logic [4:0] st;
    cur = (m_mode == M_IDLE) ? 0 :
          (m_mode == M_DONE) ? 6 :
          (m_mode == M_LOCK) ? 7 : m_phase;
    st  = (m_mode == M_RUN) ? 5'(1 << (m_phase - 1)) : 5'b00000;
    return outs(cur, st, m_mode == M_CLEAR, m_fails, (m_alarm_left > 0) || (m_mode == M_LOCK),
                m_mode == M_LOCK, m_mode == M_DONE, m_escape);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_phase = 0; m_fails = 0; m_run_cycles = 0; m_alarm_left = 0; m_escape = 0;
  endtask

  // One clock of the escape rules, expressed in terms of phases and attempts.
  task automatic model_step(input logic g, input logic [4:0] d, input logic [4:0] f);
    bit my_done, my_fail;
    m_escape = 0;
    if (m_alarm_left > 0) m_alarm_left--;
    case (m_mode)
      M_IDLE: if (g) begin m_mode = M_CLEAR; m_phase = 1; end
      M_CLEAR: begin m_mode = M_RUN; m_run_cycles = 0; end
      M_RUN: begin
        m_run_cycles++;
        my_done = d[m_phase - 1];
        my_fail = f[m_phase - 1] || (PHASE_TIMEOUT > 0 && m_run_cycles >= PHASE_TIMEOUT && !my_done);
        if (my_fail) begin
          m_fails++;
          if (m_fails >= MAX_FAILS) m_mode = M_LOCK;
          else begin
            m_alarm_left = ALARM_HOLD;
            m_mode = M_CLEAR;
            m_phase = (m_phase == 1) ? 1 : 2;
          end
        end else if (my_done) begin
          if (m_phase == 5) begin m_mode = M_DONE; m_escape = 1; end
          else begin m_phase++; m_mode = M_CLEAR; end
        end
      end
      default: ;
    endcase
  endtask

  task automatic applyStimulus(input logic g, input logic [4:0] d, input logic [4:0] f);
    go = g; phase_done = d; phase_fail = f;
    @(posedge clk);
    model_step(g, d, f);
    @(negedge clk);
    check("model", dut_vec, model_exp());
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    go = 1'b0; phase_done = '0; phase_fail = '0;
    #1 check("async_reset", dut_vec, 17'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    tbl[0]  = mk(1'b1, 5'b00000, 5'b00000, outs(1, 5'b00000, 1, 0, 0, 0, 0, 0));
    tbl[1]  = mk(1'b0, 5'b00100, 5'b11110, outs(1, 5'b00001, 0, 0, 0, 0, 0, 0));
    tbl[2]  = mk(1'b0, 5'b00001, 5'b00000, outs(2, 5'b00000, 1, 0, 0, 0, 0, 0));
    tbl[3]  = mk(1'b0, 5'b00000, 5'b00000, outs(2, 5'b00010, 0, 0, 0, 0, 0, 0));
    tbl[4]  = mk(1'b0, 5'b00010, 5'b00000, outs(3, 5'b00000, 1, 0, 0, 0, 0, 0));
    tbl[5]  = mk(1'b0, 5'b00000, 5'b00000, outs(3, 5'b00100, 0, 0, 0, 0, 0, 0));
    tbl[6]  = mk(1'b0, 5'b00100, 5'b00000, outs(4, 5'b00000, 1, 0, 0, 0, 0, 0));
    tbl[7]  = mk(1'b0, 5'b00000, 5'b00000, outs(4, 5'b01000, 0, 0, 0, 0, 0, 0));
    tbl[8]  = mk(1'b0, 5'b01000, 5'b01000, outs(2, 5'b00000, 1, 1, 1, 0, 0, 0));
    tbl[9]  = mk(1'b0, 5'b00000, 5'b00000, outs(2, 5'b00010, 0, 1, 1, 0, 0, 0));
    tbl[10] = mk(1'b0, 5'b10010, 5'b00000, outs(3, 5'b00000, 1, 1, 1, 0, 0, 0));
    tbl[11] = mk(1'b0, 5'b00000, 5'b00000, outs(3, 5'b00100, 0, 1, 1, 0, 0, 0));
    tbl[12] = mk(1'b0, 5'b00100, 5'b00000, outs(4, 5'b00000, 1, 1, 1, 0, 0, 0));
    tbl[13] = mk(1'b0, 5'b00000, 5'b00000, outs(4, 5'b01000, 0, 1, 1, 0, 0, 0));
    tbl[14] = mk(1'b0, 5'b01000, 5'b00000, outs(5, 5'b00000, 1, 1, 1, 0, 0, 0));
    tbl[15] = mk(1'b0, 5'b00000, 5'b00000, outs(5, 5'b10000, 0, 1, 1, 0, 0, 0));
    tbl[16] = mk(1'b0, 5'b10000, 5'b00000, outs(6, 5'b00000, 0, 1, 0, 0, 1, 1));
    tbl[17] = mk(1'b1, 5'b11111, 5'b11111, outs(6, 5'b00000, 0, 1, 0, 0, 1, 0));

    @(negedge clk);
    do_reset();
    for (int i = 0; i < 18; i++) begin
      applyStimulus(tbl[i].go, tbl[i].done, tbl[i].fail);
      check($sformatf("table[%0d]", i), dut_vec, tbl[i].exp);
    end

    // Clean run through all five phases without a single failure.
    do_reset();
    applyStimulus(1'b1, 5'b0, 5'b0);
    applyStimulus(1'b0, 5'b0, 5'b0);
    for (int p = 0; p < 5; p++) begin
      applyStimulus(1'b0, 5'(1 << p), 5'b0);
      if (p < 4) applyStimulus(1'b0, 5'b0, 5'b0);
    end
    check("clean_escape", dut_vec, outs(6, 5'b00000, 0, 0, 0, 0, 1, 1));
    applyStimulus(1'b0, 5'b0, 5'b0);
    check("escape_pulse_end", dut_vec, outs(6, 5'b00000, 0, 0, 0, 0, 1, 0));

    // Three failures (phase 1, phase 3, phase 2) end in lockout.
    do_reset();
    applyStimulus(1'b1, 5'b0, 5'b0);
    applyStimulus(1'b0, 5'b0, 5'b0);
    applyStimulus(1'b0, 5'b0, 5'b00001);
    check("ph1_retry", dut_vec, outs(1, 5'b00000, 1, 1, 1, 0, 0, 0));
    applyStimulus(1'b0, 5'b0, 5'b0);
    applyStimulus(1'b0, 5'b00001, 5'b0);
    applyStimulus(1'b0, 5'b0, 5'b0);
    applyStimulus(1'b0, 5'b00010, 5'b0);
    applyStimulus(1'b0, 5'b0, 5'b0);
    applyStimulus(1'b0, 5'b0, 5'b00100);
    check("ph3_rollback", dut_vec, outs(2, 5'b00000, 1, 2, 1, 0, 0, 0));
    applyStimulus(1'b0, 5'b0, 5'b0);
    applyStimulus(1'b0, 5'b0, 5'b00010);
    check("lockout_entry", dut_vec, outs(7, 5'b00000, 0, 3, 1, 1, 0, 0));
    for (int i = 0; i < 50; i++)
      applyStimulus(1'($urandom), 5'($urandom), 5'($urandom));
    check("lockout_hold", dut_vec, outs(7, 5'b00000, 0, 3, 1, 1, 0, 0));

    // Phase timeout: exactly PHASE_TIMEOUT RUN cycles, then a forced fail.
    do_reset();
    applyStimulus(1'b1, 5'b0, 5'b0);
    for (int k = 1; k <= PHASE_TIMEOUT; k++) begin
      applyStimulus(1'b0, 5'b0, 5'b0);
      check($sformatf("timeout_run[%0d]", k), dut_vec, outs(1, 5'b00001, 0, 0, 0, 0, 0, 0));
    end
    applyStimulus(1'b0, 5'b0, 5'b0);
    check("timeout_fail", dut_vec, outs(1, 5'b00000, 1, 1, 1, 0, 0, 0));
    applyStimulus(1'b0, 5'b0, 5'b0);
    check("timeout_retry", dut_vec, outs(1, 5'b00001, 0, 1, 1, 0, 0, 0));

    // Asynchronous reset in the middle of phase 3 with the alarm running.
    do_reset();
    applyStimulus(1'b1, 5'b0, 5'b0);
    applyStimulus(1'b0, 5'b0, 5'b0);
    applyStimulus(1'b0, 5'b00001, 5'b0);
    applyStimulus(1'b0, 5'b0, 5'b0);
    applyStimulus(1'b0, 5'b0, 5'b00010);
    applyStimulus(1'b0, 5'b0, 5'b0);
    applyStimulus(1'b0, 5'b00010, 5'b0);
    applyStimulus(1'b0, 5'b0, 5'b0);
    check("mid_run_ph3", dut_vec, outs(3, 5'b00100, 0, 1, 1, 0, 0, 0));
    do_reset();
    applyStimulus(1'b1, 5'b0, 5'b0);
    applyStimulus(1'b0, 5'b0, 5'b0);
    check("restart_after_reset", dut_vec, outs(1, 5'b00001, 0, 0, 0, 0, 0, 0));

    // Randomized play against the model.
    for (int ep = 0; ep < 25; ep++) begin
      do_reset();
      for (int c = 0; c < 120; c++) begin
        applyStimulus($urandom_range(0, 3) == 0,
                      ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b00000,
                      ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'b00000);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vault_sequencer.md
Name: vault_sequencer

Overview:
Master controller downstream of the five puzzle phase blocks (code, switch, maze, pressure plate, time lock). It starts each phase in turn and consumes that phase's done/fail results. On a failure it rolls play back as the escape rules require and counts the failures. It raises all_done and vault_escape on a full escape, and locks the vault out after too many failures.

Parameters:
MAX_FAILS, 3, failures allowed before lockout (1..15)
PHASE_TIMEOUT, 1000, RUN cycles allowed per phase attempt before a forced fail; 0 disables the timeout
ALARM_HOLD, 8, cycles the alarm stays high after each non-lockout failure (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
go  in  1  start request, sampled only in IDLE
phase_done  in  5  bit k = done from phase k+1
phase_fail  in  5  bit k = fail (or alarm) from phase k+1
phase_start  out  5  one-hot enable to the active phase, held for the whole attempt
phase_clear  out  1  one-cycle pulse that re-initialises the phase blocks before each attempt
cur_phase  out  3  active phase, 1..5; 0 in IDLE; 6 in DONE; 7 in LOCKOUT
fail_count  out  4  failures so far, saturates at MAX_FAILS
alarm  out  1  failure alarm
lockout  out  1  high in LOCKOUT
all_done  out  1  level, high in DONE
vault_escape  out  1  one-cycle pulse on entry to DONE

Behaviour:
- reset low, at any time including mid-attempt: state=IDLE immediately; phase_start=0, phase_clear=0, cur_phase=0, fail_count=0, alarm=0, lockout=0, all_done=0, vault_escape=0; phase timer=0, alarm timer=0.
- States: IDLE, CLEAR, RUN, DONE, LOCKOUT. All outputs are registered.
- IDLE: when go=1, next state=CLEAR with target phase 1.
- CLEAR (exactly 1 cycle):
  - phase_clear=1, phase_start=0, cur_phase=target, phase timer cleared.
  - Next state=RUN.
- RUN, phase k:
  - phase_start = one-hot bit k-1; timer increments by 1 each cycle.
  - Only bit k-1 of phase_done and phase_fail is examined. All other bits are ignored in every state.
- RUN, fail event: phase_fail[k-1]=1, or PHASE_TIMEOUT!=0 and timer reaches PHASE_TIMEOUT-1 with no done in that cycle.
  - Fail wins over a simultaneous done.
- RUN, done (no fail):
  - k<5: CLEAR with target k+1.
  - k=5: DONE.
- RUN, fail event:
  - fail_count increments.
  - If the new count equals MAX_FAILS: next state=LOCKOUT.
  - Otherwise: alarm timer loaded with ALARM_HOLD, then CLEAR with rollback target.
  - Rollback target: phase 1 for a phase-1 fail, phase 2 for any fail in phases 2..5.
- alarm: high for ALARM_HOLD cycles starting the cycle after the fail event, counting down independently of state.
  - A new fail reloads the count.
  - alarm is forced high continuously in LOCKOUT.
- DONE:
  - all_done=1 and cur_phase=6; vault_escape=1 only in the first DONE cycle.
  - phase_start=0; go is ignored; held until reset.
- LOCKOUT: lockout=1, alarm=1, cur_phase=7, phase_start=0; all inputs ignored; held until reset.
- Latency:
  - go to phase_start[0] high: 2 cycles.
  - phase done to next phase_start: 2 cycles (one RUN-exit edge, one CLEAR cycle).
- fail_count never wraps. It is 4 bits wide and stops at MAX_FAILS.

Test Plan:
- Reset low, then high; go=1 for 1 cycle -> phase_clear pulses 1 cycle, then phase_start=00001, cur_phase=1; all other outputs 0.
- Assert phase_done[k-1] for 1 cycle in each phase 1..5 -> phase_start steps 00001,00010,00100,01000,10000, with a 1-cycle phase_clear between each step. Then all_done=1, vault_escape high exactly 1 cycle, cur_phase=6, fail_count=0.
- During phase 4, pulse phase_fail[3] -> fail_count=1; alarm high exactly 8 cycles; next phase_start=00010 (rollback to phase 2). In phase 1, a fail retries phase 1.
- Three fails (phase 1, phase 3, phase 2) -> after the third, lockout=1, alarm=1 steady, cur_phase=7, phase_start=0. go and phase_done are then ignored for 50 cycles.
- PHASE_TIMEOUT=10, no inputs in phase 1 -> fail after exactly 10 RUN cycles; fail_count=1; phase 1 retried. Simultaneous phase_done[0] and phase_fail[0] -> treated as a fail. phase_done[2] asserted while in phase 1 -> ignored.
- Assert reset mid-RUN in phase 3 with alarm active -> all outputs 0 asynchronously. After release, go restarts at phase 1 with fail_count=0.
